// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences MEM-stage loads and stores onto a variable-latency SRAM-like
//   data port (req / addr_ok / data_ok). It tracks one outstanding transaction,
//   stalls the pipeline while the access is in flight, and returns aligned,
//   sign/zero-extended load data to the MEM writeback mux.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   stall[STALL_W]                pipeline stall bus; bit 4 holds the MEM stage
//   req_valid/wen/addr/wdata      MEM-stage access (wen == 0 means load)
//   req_ld_type                   0=LW 1=LB 2=LBU 3=LH 4=LHU
//   sram_req/wr/wstrb/addr/wdata  request side of the SRAM port
//   sram_addr_ok/data_ok/rdata    response side of the SRAM port
//   stallreq_mem                  stall request to the control unit
//   load_data/load_valid          extended load result for the MEM instruction

module mem_access_ctrl #(
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               req_valid,
  input  logic [3:0]         req_wen,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [2:0]         req_ld_type,
  output logic               sram_req,
  output logic               sram_wr,
  output logic [3:0]         sram_wstrb,
  output logic [31:0]        sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic               sram_addr_ok,
  input  logic               sram_data_ok,
  input  logic [31:0]        sram_rdata,
  output logic               stallreq_mem,
  output logic [31:0]        load_data,
  output logic               load_valid
);

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [2:0]  ld_type_q;
  logic [31:0] rdata_ext;

  // Only the MEM-stage hold bit matters here; the rest of the bus is
  // folded into a deliberately unused signal.
  logic unused_stall;
  assign unused_stall = &{1'b0, stall};

  // Extract and extend the addressed lane. Stores complete with zero so
  // the writeback side sees a uniform handshake for every access.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    lane_b    = sram_rdata[8*sram_addr[1:0] +: 8];
    lane_h    = sram_rdata[16*sram_addr[1] +: 16];
    rdata_ext = sram_rdata;
    if (sram_wr) begin
      rdata_ext = '0;
    end else begin
      case (ld_type_q)
        LD_LW:   rdata_ext = sram_rdata;
        LD_LB:   rdata_ext = {{24{lane_b[7]}}, lane_b};
        LD_LBU:  rdata_ext = {24'd0, lane_b};
        LD_LH:   rdata_ext = {{16{lane_h[15]}}, lane_h};
        LD_LHU:  rdata_ext = {16'd0, lane_h};
        default: rdata_ext = sram_rdata;
      endcase
    end
  end

  // In IDLE the stall must be raised in the same cycle the access appears,
  // so it follows req_valid directly; afterwards it depends on state only.
  assign stallreq_mem = (state == IDLE) ? req_valid : (state != HOLD);

  // The latched request lives directly in the sram_* output registers, so
  // address and data stay stable for the whole REQ phase.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst) begin
      state      <= IDLE;
      sram_req   <= 1'b0;
      sram_wr    <= 1'b0;
      sram_wstrb <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      ld_type_q  <= LD_LW;
      load_data  <= '0;
      load_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Late data_ok responses land here and are simply ignored.
          if (req_valid) begin
            sram_req   <= 1'b1;
            sram_wr    <= |req_wen;
            sram_wstrb <= req_wen;
            sram_addr  <= req_addr;
            sram_wdata <= req_wdata;
            ld_type_q  <= req_ld_type;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sram_addr_ok) begin
            sram_req <= 1'b0;
            if (sram_data_ok) begin
              load_data  <= rdata_ext;
              load_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (sram_data_ok) begin
            load_data  <= rdata_ext;
            load_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          // The MEM instruction retires on the first edge without a hold.
          if (!stall[4]) begin
            load_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Scoreboard bench for mem_access_ctrl: expected load results are queued
//   when an access is issued and compared when the block reports load_valid.
//   Inputs are driven and outputs sampled on the falling clock edge.

module tb_mem_access_ctrl;

  localparam logic [2:0] LW  = 3'd0;
  localparam logic [2:0] LB  = 3'd1;
  localparam logic [2:0] LBU = 3'd2;
  localparam logic [2:0] LH  = 3'd3;
  localparam logic [2:0] LHU = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        req_valid;
  logic [3:0]  req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ld_type;
  logic        sram_req;
  logic        sram_wr;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_addr_ok;
  logic        sram_data_ok;
  logic [31:0] sram_rdata;
  logic        stallreq_mem;
  logic [31:0] load_data;
  logic        load_valid;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_access_ctrl #(.STALL_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .req_valid    (req_valid),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ld_type  (req_ld_type),
    .sram_req     (sram_req),
    .sram_wr      (sram_wr),
    .sram_wstrb   (sram_wstrb),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_addr_ok (sram_addr_ok),
    .sram_data_ok (sram_data_ok),
    .sram_rdata   (sram_rdata),
    .stallreq_mem (stallreq_mem),
    .load_data    (load_data),
    .load_valid   (load_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result: shift the addressed lane down, then extend.
  function automatic logic [31:0] model(input logic [3:0] wen, input logic [31:0] addr,
                                        input logic [2:0] ld, input logic [31:0] rdata);
    logic [31:0] sh;
    if (wen != 4'h0) return 32'h0;
    sh = rdata >> {addr[1:0], 3'b000};
    case (ld)
      LB:  return {{24{sh[7]}}, sh[7:0]};
      LBU: return {24'h0, sh[7:0]};
      LH: begin
        sh = rdata >> {addr[1], 4'b0000};
        return {{16{sh[15]}}, sh[15:0]};
      end
      LHU: begin
        sh = rdata >> {addr[1], 4'b0000};
        return {16'h0, sh[15:0]};
      end
      default: return rdata;
    endcase
  endfunction

  task automatic idle_inputs();
    req_valid    = 1'b0;
    req_wen      = 4'h0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_ld_type  = LW;
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b0;
    sram_rdata   = 32'h5A5A_5A5A;
    stall        = 6'b10_0000;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sram_req"},  sram_req,     0);
    check({tag, "_sram_wr"},   sram_wr,      0);
    check({tag, "_wstrb"},     sram_wstrb,   0);
    check({tag, "_addr"},      sram_addr,    0);
    check({tag, "_wdata"},     sram_wdata,   0);
    check({tag, "_ld_data"},   load_data,    0);
    check({tag, "_ld_valid"},  load_valid,   0);
    check({tag, "_stallreq"},  stallreq_mem, 0);
  endtask

  // One complete access. a_cycles = REQ cycles (addr_ok in the last one),
  // d_cycles = WAIT cycles (0 means data_ok together with addr_ok),
  // hold_cycles = HOLD cycles with stall[4] held before retirement.
  task automatic do_access(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] ld,
                           input logic [31:0] rdata, input int a_cycles,
                           input int d_cycles, input int hold_cycles);
    logic [31:0] exp;
    exp = 32'h0;
    // Cycle 0: IDLE accepts the request.
    @(negedge clk);
    check({tag, "_idle_lv"},  load_valid,   0);
    check({tag, "_idle_sr"},  stallreq_mem, 0);
    check({tag, "_idle_req"}, sram_req,     0);
    req_valid   = 1'b1;
    req_wen     = wen;
    req_addr    = addr;
    req_wdata   = wdata;
    req_ld_type = ld;
    exp_q.push_back(model(wen, addr, ld, rdata));
    #1 check({tag, "_c0_stallreq"}, stallreq_mem, 1);
    // REQ phase; request inputs carry junk that must be ignored.
    for (int i = 1; i <= a_cycles; i++) begin
      @(negedge clk);
      req_valid   = 1'b1;
      req_addr    = 32'hBAD0_0000 ^ i;
      req_wdata   = ~wdata;
      req_wen     = ~wen;
      check({tag, "_req"},      sram_req,     1);
      check({tag, "_addr"},     sram_addr,    addr);
      check({tag, "_wdata"},    sram_wdata,   wdata);
      check({tag, "_wstrb"},    sram_wstrb,   wen);
      check({tag, "_wr"},       sram_wr,      |wen);
      check({tag, "_req_sr"},   stallreq_mem, 1);
      check({tag, "_req_lv"},   load_valid,   0);
      sram_addr_ok = (i == a_cycles);
      sram_data_ok = (i == a_cycles) && (d_cycles == 0);
      sram_rdata   = sram_data_ok ? rdata : 32'h5A5A_5A5A;
    end
    // WAIT phase.
    for (int i = 1; i <= d_cycles; i++) begin
      @(negedge clk);
      req_valid    = 1'b1;
      req_addr     = 32'hBAD1_0000 ^ i;
      sram_addr_ok = 1'b0;
      check({tag, "_wait_req"}, sram_req,     0);
      check({tag, "_wait_sr"},  stallreq_mem, 1);
      check({tag, "_wait_lv"},  load_valid,   0);
      sram_data_ok = (i == d_cycles);
      sram_rdata   = sram_data_ok ? rdata : 32'h5A5A_5A5A;
    end
    // HOLD phase: result must appear and stay put while the stage is held.
    for (int i = 0; i <= hold_cycles; i++) begin
      @(negedge clk);
      req_valid    = 1'b0;
      sram_addr_ok = 1'b0;
      sram_data_ok = 1'b0;
      sram_rdata   = 32'hA5A5_A5A5;
      if (i == 0) begin
        check({tag, "_hold_lv0"}, load_valid, 1);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
      end else begin
        check({tag, "_hold_lv"}, load_valid, 1);
      end
      check({tag, "_load_data"}, load_data,    exp);
      check({tag, "_hold_sr"},   stallreq_mem, 0);
      check({tag, "_hold_req"},  sram_req,     0);
      stall = (i < hold_cycles) ? 6'b11_0000 : 6'b10_0000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst = 1'b0;

    // Reset in the middle of WAIT, followed by a late data_ok.
    @(negedge clk);
    req_valid   = 1'b1;
    req_addr    = 32'h0000_0040;
    req_ld_type = LW;
    @(negedge clk);
    idle_inputs();
    check("mw_req", sram_req, 1);
    sram_addr_ok = 1'b1;
    @(negedge clk);
    sram_addr_ok = 1'b0;
    check("mw_wait_req", sram_req, 0);
    check("mw_wait_sr",  stallreq_mem, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mw_rst");
    sram_data_ok = 1'b1;
    sram_rdata   = 32'h1111_1111;
    @(negedge clk);
    sram_data_ok = 1'b0;
    check("mw_late_lv",   load_valid,   0);
    check("mw_late_data", load_data,    0);
    check("mw_late_req",  sram_req,     0);
    check("mw_late_sr",   stallreq_mem, 0);
    @(negedge clk);
    check("mw_late_lv2",  load_valid,   0);

    // Minimum-latency LW.
    do_access("lw",  4'h0, 32'h0000_0100, 32'h0, LW,  32'hDEAD_BEEF, 1, 1, 0);
    // Sub-word loads with extension.
    do_access("lb",  4'h0, 32'h0000_0103, 32'h0, LB,  32'h8011_2233, 1, 1, 0);
    do_access("lbu", 4'h0, 32'h0000_0103, 32'h0, LBU, 32'h8011_2233, 1, 1, 0);
    do_access("lh",  4'h0, 32'h0000_0102, 32'h0, LH,  32'h8011_2233, 1, 1, 0);
    do_access("lhu", 4'h0, 32'h0000_0102, 32'h0, LHU, 32'h8011_2233, 1, 1, 0);
    do_access("lb1", 4'h0, 32'h0000_0101, 32'h0, LB,  32'h8011_2233, 1, 2, 0);
    // Store with addr_ok delayed three cycles.
    do_access("sw",  4'hF, 32'h0000_0200, 32'hCAFE_F00D, LW, 32'h7777_7777, 4, 2, 0);
    do_access("sb",  4'h2, 32'h0000_0301, 32'h0000_AB00, LB, 32'h1234_5678, 2, 1, 0);
    // addr_ok and data_ok together: WAIT is skipped.
    do_access("same", 4'h0, 32'h0000_0200, 32'h0, LH, 32'hCAFE_9ABC, 1, 0, 0);
    // Held in HOLD for two cycles, then a back-to-back request.
    do_access("held", 4'h0, 32'h0000_0400, 32'h0, LHU, 32'hFEDC_BA98, 2, 1, 2);
    do_access("b2b",  4'h0, 32'h0000_0402, 32'h0, LBU, 32'hFEDC_BA98, 1, 1, 0);

    @(negedge clk);
    check("end_lv", load_valid,   0);
    check("end_sr", stallreq_mem, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences every MEM-stage load/store onto a variable-latency SRAM-like data port (req / addr_ok / data_ok). The block sits between the MEM pipeline stage and the data SRAM. It raises a stall request while an access is in flight, and it returns aligned, sign/zero-extended load data to the MEM writeback mux. It tracks exactly one outstanding transaction.

Parameters:
STALL_W, 6, width of the pipeline stall bus; bit 4 set means the MEM stage is held.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
stall  in  STALL_W  pipeline stall bus from the control unit
req_valid  in  1  MEM-stage instruction needs data memory (data_ram_en)
req_wen  in  4  byte write strobes; 0 means load
req_addr  in  32  byte address
req_wdata  in  32  store data, already lane-aligned
req_ld_type  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU
sram_req  out  1  access request to SRAM
sram_wr  out  1  1 = write
sram_wstrb  out  4  byte strobes
sram_addr  out  32  address, held stable while sram_req=1
sram_wdata  out  32  write data
sram_addr_ok  in  1  SRAM accepted the request
sram_data_ok  in  1  SRAM completed (rdata valid / write done)
sram_rdata  in  32  read data
stallreq_mem  out  1  stall request to the control unit
load_data  out  32  extended load result
load_valid  out  1  load_data is valid for the current MEM instruction

Behaviour:
- FSM states: IDLE, REQ, WAIT, HOLD.
- Reset (sync, rst=1): state=IDLE. All outputs are 0: sram_req, sram_wr, sram_wstrb, sram_addr, sram_wdata, load_data, load_valid, stallreq_mem. Reset mid-transaction abandons the access; sram_req=0 on the next cycle.
- IDLE:
  - If req_valid=1, latch addr, wen, wdata and ld_type, then go to REQ.
  - stallreq_mem = req_valid (combinational).
  - A sram_data_ok seen in IDLE is discarded.
- REQ:
  - sram_req=1; sram_wr=|wen; sram_wstrb=wen; sram_addr/sram_wdata come from the latched values and are stable until addr_ok.
  - On addr_ok=1 with data_ok=0: go to WAIT.
  - On addr_ok=1 with data_ok=1 in the same cycle: capture data and go to HOLD.
  - stallreq_mem=1.
- WAIT:
  - sram_req=0.
  - On data_ok=1: register the extracted data into load_data and go to HOLD.
  - stallreq_mem=1.
- HOLD:
  - load_valid=1 and stallreq_mem=0.
  - load_data stays constant while stall[4]=1.
  - When stall[4]=0 the MEM instruction retires at this edge: go to IDLE and clear load_valid.
- Load extraction uses off=addr[1:0]:
  - LB/LBU take byte rdata[8*off+:8], sign- or zero-extended.
  - LH/LHU take rdata[16*off[1]+:16], extended.
  - LW takes rdata unchanged.
- Stores: load_data=0 and load_valid=1 in HOLD, so completion is uniform.
- Alignment is the issuer's responsibility. The address is passed unchanged and no exception is raised.
- Minimum access latency, with addr_ok in the first REQ cycle and data_ok in the first WAIT cycle:
  - Cycle 0: IDLE accepts the request.
  - Cycle 1: REQ.
  - Cycle 2: WAIT.
  - Cycle 3: HOLD.
  - The MEM stage is stalled for 3 cycles.
- req_* inputs are ignored outside IDLE.

Test Plan:
1. Reset mid-WAIT: rst=1 for 1 cycle, then a late data_ok arrives → state IDLE, sram_req=0, data_ok dropped, load_valid=0, stallreq_mem=0.
2. LW from addr 0x100, addr_ok in cycle 1, data_ok in cycle 2, rdata=0xDEADBEEF, stall[4]=0 → sram_req high only in cycle 1, stallreq_mem high in cycles 0–2, load_data=0xDEADBEEF with load_valid=1 in cycle 3, IDLE in cycle 4.
3. LB addr 0x103 and rdata=0x80112233 → 0xFFFFFF80. LBU same → 0x00000080. LH addr 0x102 → 0xFFFF8011. LHU → 0x00008011.
4. SW with wen=4'hF, addr_ok delayed 3 cycles → sram_addr/sram_wdata/sram_wstrb stable throughout REQ, sram_wr=1, load_data=0 in HOLD.
5. addr_ok and data_ok in the same REQ cycle → next state is HOLD (WAIT skipped), with the correct data.
6. In HOLD, stall[4]=1 for 2 cycles → load_valid and load_data constant, stallreq_mem=0; IDLE the cycle after stall[4] drops; back-to-back req_valid is then accepted immediately.
